// File: rtl/bcd_to_bin_pkg.sv
// Shared definitions for the BCD-to-binary converter.
//   DIGIT_W    : width of one BCD digit
//   RESULT_W   : default width of the binary result
//   NUM_DIGITS : default number of digits converted per request
//   TEN        : decimal radix
//   state_t    : controller state encoding (IDLE, CONV, DONE)
package bcd_to_bin_pkg;

  localparam int DIGIT_W    = 4;
  localparam int RESULT_W   = 16;
  localparam int NUM_DIGITS = 5;
  localparam int TEN        = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_to_bin_times10_add.sv
// Combinational multiply-by-ten-and-add: sum = acc*10 + digit.
// Built from two shifts and adds so no multiplier is inferred.
//   acc   : running accumulator (ACC_W bits)
//   digit : BCD digit to add
//   sum   : full-width result (ACC_W+4 bits, cannot wrap)
module times10_add
  import bcd_to_bin_pkg::*;
#(
  parameter int ACC_W = RESULT_W + 1,
  parameter int SUM_W = ACC_W + 4
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [SUM_W-1:0]   sum
);

  logic [SUM_W-1:0] acc_ext;

  assign acc_ext = SUM_W'(acc);
  assign sum     = (acc_ext << 3) + (acc_ext << 1) + SUM_W'(digit);

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter, one digit per clock, MSD first.
//   clk, reset          : clock, asynchronous active-high reset
//   start               : request, sampled only in IDLE
//   digit_5 .. digit_1  : BCD digits, ten-thousands down to units
//   result              : binary value of the last completed conversion
//   busy                : conversion in progress
//   done                : one-cycle pulse when result/flags update
//   overflow            : last value exceeded 2^RESULT_W-1 (saturated)
//   bad_digit           : last request held a digit above 9 (result 0)
module bcd_to_bin
  import bcd_to_bin_pkg::*;
#(
  parameter int NUM_DIGITS = bcd_to_bin_pkg::NUM_DIGITS,
  parameter int RESULT_W   = bcd_to_bin_pkg::RESULT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DIGIT_W-1:0]  digit_5,
  input  logic [DIGIT_W-1:0]  digit_4,
  input  logic [DIGIT_W-1:0]  digit_3,
  input  logic [DIGIT_W-1:0]  digit_2,
  input  logic [DIGIT_W-1:0]  digit_1,
  output logic [RESULT_W-1:0] result,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                bad_digit
);

  localparam int ACC_W  = RESULT_W + 1;
  localparam int SUM_W  = ACC_W + 4;
  localparam int SREG_W = 5 * DIGIT_W;
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);

  state_t                state, state_nxt;
  logic [SREG_W-1:0]     sreg;
  logic [ACC_W-1:0]      acc;
  logic [CNT_W-1:0]      cnt;
  logic                  ovf_acc;
  logic                  bad_acc;
  logic [SUM_W-1:0]      sum;
  logic                  ovf_now;
  logic                  last;
  logic                  any_bad;
  logic [RESULT_W-1:0]   result_q;
  logic                  overflow_q;
  logic                  bad_q;

  function automatic logic is_bad(input logic [DIGIT_W-1:0] d);
    return d > DIGIT_W'(TEN - 1);
  endfunction

  // Saturation: a bad digit forces zero, overflow forces all ones.
  function automatic logic [RESULT_W-1:0] sat_result(input logic [SUM_W-1:0] v,
                                                     input logic ovf,
                                                     input logic bad);
    if (bad) return '0;
    if (ovf) return '1;
    return v[RESULT_W-1:0];
  endfunction

  times10_add #(
    .ACC_W (ACC_W),
    .SUM_W (SUM_W)
  ) u_times10_add (
    .acc   (acc),
    .digit (sreg[SREG_W-1 -: DIGIT_W]),
    .sum   (sum)
  );

  assign any_bad = is_bad(digit_5) | is_bad(digit_4) | is_bad(digit_3) |
                   is_bad(digit_2) | is_bad(digit_1);
  // Overflow is sticky: once any partial value leaves the range it stays set.
  assign ovf_now = ovf_acc | (sum > SUM_W'({RESULT_W{1'b1}}));
  assign last    = (cnt == CNT_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture in IDLE, accumulate in CONV, publish on the last digit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg       <= '0;
      acc        <= '0;
      cnt        <= '0;
      ovf_acc    <= 1'b0;
      bad_acc    <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sreg    <= {digit_5, digit_4, digit_3, digit_2, digit_1};
            acc     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            bad_acc <= any_bad;
          end
        end
        CONV: begin
          acc     <= sum[ACC_W-1:0];
          sreg    <= sreg << DIGIT_W;
          cnt     <= cnt + 1'b1;
          ovf_acc <= ovf_now;
          if (last) begin
            result_q   <= sat_result(sum, ovf_now, bad_acc);
            overflow_q <= ovf_now & ~bad_acc;
            bad_q      <= bad_acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign overflow  = overflow_q;
  assign bad_digit = bad_q;
  assign busy      = (state == CONV);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  digit_5, digit_4, digit_3, digit_2, digit_1;
  logic [15:0] result;
  logic        busy, done, overflow, bad_digit;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  bcd_to_bin dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .digit_5   (digit_5),
    .digit_4   (digit_4),
    .digit_3   (digit_3),
    .digit_2   (digit_2),
    .digit_1   (digit_1),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .bad_digit (bad_digit)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: decimal value of the five digits, then the output rules.
  task automatic ref_conv(input logic [3:0] a, b, c, d, e,
                          output int res, output int ovf, output int bad);
    int v;
    bad = (a > 9 || b > 9 || c > 9 || d > 9 || e > 9) ? 1 : 0;
    v   = a * 10000 + b * 1000 + c * 100 + d * 10 + e;
    if (bad != 0) begin
      res = 0; ovf = 0;
    end else if (v > 65535) begin
      res = 65535; ovf = 1;
    end else begin
      res = v; ovf = 0;
    end
  endtask

  // Call just after a negedge with the DUT idle.
  // mode 0: plain; 1: digits scrambled after capture; 2: start pulsed mid-conversion.
  task automatic do_conv(input string tag, input logic [3:0] a, b, c, d, e, input int mode);
    int exp_res, exp_ovf, exp_bad, lat, n0;
    ref_conv(a, b, c, d, e, exp_res, exp_ovf, exp_bad);
    n0 = done_cnt;
    digit_5 = a; digit_4 = b; digit_3 = c; digit_2 = d; digit_1 = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, ".busy"}, 32'(busy), 32'd1);
    if (mode == 1) begin
      digit_5 = 4'($urandom); digit_4 = 4'($urandom); digit_3 = 4'($urandom);
      digit_2 = 4'($urandom); digit_1 = 4'($urandom);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mode == 2 && lat == 2) begin
        start = 1'b1;
        digit_5 = 4'd0; digit_4 = 4'd0; digit_3 = 4'd0;
        digit_2 = 4'($urandom_range(0, 9)); digit_1 = 4'd7;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq({tag, ".latency"}, 32'(lat), 32'd5);
    check_eq({tag, ".result"}, 32'(result), 32'(exp_res));
    check_eq({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
    check_eq({tag, ".bad_digit"}, 32'(bad_digit), 32'(exp_bad));
    @(negedge clk);
    check_eq({tag, ".done_pulse"}, 32'(done), 32'd0);
    if (mode == 2) repeat (10) @(negedge clk);
    check_eq({tag, ".done_count"}, 32'(done_cnt - n0), 32'd1);
    check_eq({tag, ".held"}, 32'(result), 32'(exp_res));
  endtask

  initial begin
    logic [3:0] r[5];
    int n0;
    reset = 1'b1; start = 1'b0;
    digit_5 = '0; digit_4 = '0; digit_3 = '0; digit_2 = '0; digit_1 = '0;
    #1;
    check_eq("rst.result", 32'(result), 32'd0);
    check_eq("rst.busy", 32'(busy), 32'd0);
    check_eq("rst.done", 32'(done), 32'd0);
    check_eq("rst.flags", 32'({overflow, bad_digit}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    do_conv("d123",   4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 0);
    do_conv("d65535", 4'd6, 4'd5, 4'd5, 4'd3, 4'd5, 0);
    do_conv("d65536", 4'd6, 4'd5, 4'd5, 4'd3, 4'd6, 0);
    do_conv("d99999", 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 0);
    do_conv("dbad",   4'd1, 4'd2, 4'hA, 4'd0, 4'd0, 0);
    do_conv("dchg",   4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 1);
    do_conv("dstart", 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 2);

    // Abort a conversion with reset two clocks after capture.
    digit_5 = 4'd1; digit_4 = 4'd2; digit_3 = 4'd3; digit_2 = 4'd4; digit_1 = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n0 = done_cnt;
    reset = 1'b1;
    #1;
    check_eq("abort.result", 32'(result), 32'd0);
    check_eq("abort.busy", 32'(busy), 32'd0);
    check_eq("abort.done", 32'(done), 32'd0);
    check_eq("abort.flags", 32'({overflow, bad_digit}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_conv("d42", 4'd0, 4'd0, 4'd0, 4'd4, 4'd2, 0);
    check_eq("abort.no_done", 32'(done_cnt - n0), 32'd1);

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 5; k++) r[k] = 4'($urandom_range(0, 9));
      if (i % 3 == 0) begin r[0] = 4'd6; r[1] = 4'd5; r[2] = 4'd5; end
      if (i % 8 == 5) r[$urandom_range(0, 4)] = 4'($urandom_range(10, 15));
      do_conv("rand", r[0], r[1], r[2], r[3], r[4], i % 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
